multicycle_ctrl: RTL and testbench

- Main control FSM for the multicycle RISC-V core.
- Sequences the shared ALU, memory port, instruction register and register file across cycles per instruction.
- Drives aluOp into the ALU decoder, plus all mux selects and write enables.
- Supports lw, sw, R-type, I-type ALU, beq and jal.
- Waits on a memory-ready handshake for every memory access.

---
 rtl/multicycle_pkg.sv | 57 +++++
 rtl/mc_out_deco.sv | 77 +++++++
 rtl/multicycle_ctrl.sv | 100 ++++++++++
 tb/tb_multicycle_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_pkg.sv
// Shared types and constants for the multicycle RISC-V control path.
// Select encodings match the datapath muxes and the ALU decoder's aluOp contract.
package multicycle_pkg;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBeq      = 4'd9,
    StJal      = 4'd10
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // fetchEn marks the fetch state; irWrite/pcWrite are qualified by memReady at the top.
  typedef struct packed {
    logic       memReq;
    logic       memWrite;
    logic       adrSrc;
    logic       fetchEn;
    logic       pcUpdate;
    logic       branch;
    logic       regWrite;
    logic [1:0] resultSrc;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
  } ctrlWord_t;

endpackage

// File: rtl/mc_out_deco.sv
// Moore output decode: FSM state to raw control word.
module mc_out_deco
  import multicycle_pkg::*;
(
  input  state_e    state,
  output ctrlWord_t ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      StFetch: begin
        ctrl.memReq    = 1'b1;
        ctrl.fetchEn   = 1'b1;
        ctrl.resultSrc = RES_ALU;
        ctrl.aluSrcA   = SRCA_PC;
        ctrl.aluSrcB   = SRCB_FOUR;
        ctrl.aluOp     = ALUOP_ADD;
      end
      StDecode: begin
        ctrl.aluSrcA = SRCA_OLDPC;
        ctrl.aluSrcB = SRCB_IMM;
        ctrl.aluOp   = ALUOP_ADD;
      end
      StMemAdr: begin
        ctrl.aluSrcA = SRCA_RS1;
        ctrl.aluSrcB = SRCB_IMM;
        ctrl.aluOp   = ALUOP_ADD;
      end
      StMemRead: begin
        ctrl.memReq    = 1'b1;
        ctrl.adrSrc    = 1'b1;
        ctrl.resultSrc = RES_ALUOUT;
      end
      StMemWb: begin
        ctrl.resultSrc = RES_DATA;
        ctrl.regWrite  = 1'b1;
      end
      StMemWrite: begin
        ctrl.memReq    = 1'b1;
        ctrl.memWrite  = 1'b1;
        ctrl.adrSrc    = 1'b1;
        ctrl.resultSrc = RES_ALUOUT;
      end
      StExecR: begin
        ctrl.aluSrcA = SRCA_RS1;
        ctrl.aluSrcB = SRCB_RS2;
        ctrl.aluOp   = ALUOP_FUNCT;
      end
      StExecI: begin
        ctrl.aluSrcA = SRCA_RS1;
        ctrl.aluSrcB = SRCB_IMM;
        ctrl.aluOp   = ALUOP_FUNCT;
      end
      StAluWb: begin
        ctrl.resultSrc = RES_ALUOUT;
        ctrl.regWrite  = 1'b1;
      end
      StBeq: begin
        ctrl.aluSrcA   = SRCA_RS1;
        ctrl.aluSrcB   = SRCB_RS2;
        ctrl.aluOp     = ALUOP_SUB;
        ctrl.resultSrc = RES_ALUOUT;
        ctrl.branch    = 1'b1;
      end
      StJal: begin
        ctrl.aluSrcA   = SRCA_OLDPC;
        ctrl.aluSrcB   = SRCB_FOUR;
        ctrl.aluOp     = ALUOP_ADD;
        ctrl.resultSrc = RES_ALUOUT;
        ctrl.pcUpdate  = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle core: state register, next-state logic,
// pcWrite gating and the illegal-instruction flag.
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter bit ILLEGAL_STICKY = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       memReady,
  output logic       memReq,
  output logic       memWrite,
  output logic       adrSrc,
  output logic       irWrite,
  output logic       pcWrite,
  output logic       regWrite,
  output logic [1:0] resultSrc,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic       illegalInstr
);

  state_e    stateQ, stateD;
  logic      illegalQ, illegalSet;
  logic      fetchGo;
  ctrlWord_t ctrl;

  mc_out_deco uDeco (
    .state (stateQ),
    .ctrl  (ctrl)
  );

  always_comb begin
    stateD     = stateQ;
    illegalSet = 1'b0;
    unique case (stateQ)
      StFetch:    if (memReady) stateD = StDecode;
      StDecode: begin
        case (op)
          OP_LOAD, OP_STORE: stateD = StMemAdr;
          OP_RTYPE:          stateD = StExecR;
          OP_ITYPE:          stateD = StExecI;
          OP_BRANCH:         stateD = StBeq;
          OP_JAL:            stateD = StJal;
          default: begin
            stateD     = StFetch;
            illegalSet = 1'b1;
          end
        endcase
      end
      StMemAdr:   stateD = (op == OP_LOAD) ? StMemRead : StMemWrite;
      StMemRead:  if (memReady) stateD = StMemWb;
      StMemWb:    stateD = StFetch;
      StMemWrite: if (memReady) stateD = StFetch;
      StExecR:    stateD = StAluWb;
      StExecI:    stateD = StAluWb;
      StAluWb:    stateD = StFetch;
      StBeq:      stateD = StFetch;
      StJal:      stateD = StAluWb;
      default:    stateD = StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= StFetch;
    end else begin
      stateQ <= stateD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegalQ <= 1'b0;
    end else if (ILLEGAL_STICKY) begin
      illegalQ <= illegalQ | illegalSet;
    end else begin
      illegalQ <= illegalSet;
    end
  end

  // rst_n qualifies the fetch strobes so nothing is loaded while reset is held.
  assign fetchGo = ctrl.fetchEn & memReady & rst_n;

  assign memReq       = ctrl.memReq;
  assign memWrite     = ctrl.memWrite;
  assign adrSrc       = ctrl.adrSrc;
  assign irWrite      = fetchGo;
  assign pcWrite      = fetchGo | ctrl.pcUpdate | (ctrl.branch & zero);
  assign regWrite     = ctrl.regWrite;
  assign resultSrc    = ctrl.resultSrc;
  assign aluSrcA      = ctrl.aluSrcA;
  assign aluSrcB      = ctrl.aluSrcB;
  assign aluOp        = ctrl.aluOp;
  assign illegalInstr = illegalQ;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: sticky and pulse variants run side by side.
module tb_multicycle_ctrl;

  typedef enum int {
    TFetch, TDecode, TMemAdr, TMemRead, TMemWb, TMemWrite,
    TExecR, TExecI, TAluWb, TBeq, TJal
  } tbSt_e;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = 7'd0;
  logic       zero = 1'b0;
  logic       memReady = 1'b0;

  logic       memReqA, memWriteA, adrSrcA, irWriteA, pcWriteA, regWriteA, illA;
  logic [1:0] resultSrcA, aluSrcAA, aluSrcBA, aluOpA;
  logic       memReqB, memWriteB, adrSrcB, irWriteB, pcWriteB, regWriteB, illB;
  logic [1:0] resultSrcB, aluSrcAB, aluSrcBB, aluOpB;

  multicycle_ctrl #(.ILLEGAL_STICKY(1'b1)) dutSticky (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .memReady(memReady),
    .memReq(memReqA), .memWrite(memWriteA), .adrSrc(adrSrcA), .irWrite(irWriteA),
    .pcWrite(pcWriteA), .regWrite(regWriteA), .resultSrc(resultSrcA),
    .aluSrcA(aluSrcAA), .aluSrcB(aluSrcBA), .aluOp(aluOpA), .illegalInstr(illA)
  );

  multicycle_ctrl #(.ILLEGAL_STICKY(1'b0)) dutPulse (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .memReady(memReady),
    .memReq(memReqB), .memWrite(memWriteB), .adrSrc(adrSrcB), .irWrite(irWriteB),
    .pcWrite(pcWriteB), .regWrite(regWriteB), .resultSrc(resultSrcB),
    .aluSrcA(aluSrcAB), .aluSrcB(aluSrcBB), .aluOp(aluOpB), .illegalInstr(illB)
  );

  wire [14:0] obsA = {memReqA, memWriteA, adrSrcA, irWriteA, pcWriteA, regWriteA,
                      resultSrcA, aluSrcAA, aluSrcBA, aluOpA, illA};
  wire [14:0] obsB = {memReqB, memWriteB, adrSrcB, irWriteB, pcWriteB, regWriteB,
                      resultSrcB, aluSrcAB, aluSrcBB, aluOpB, illB};

  always #5 clk = ~clk;

  int         nCmp = 0;
  int         nErr = 0;
  logic [15:0] expQ[$];
  bit          rdyQ[$];
  logic [6:0]  opQ[$];
  bit          zQ[$];
  string       tagQ[$];
  bit          illExp = 1'b0;
  bit          pulseNext = 1'b0;
  logic [6:0]  opCur = 7'd0;
  bit          zCur = 1'b0;

  // Fields: memReq memWrite adrSrc irWrite pcWrite regWrite resultSrc aluSrcA aluSrcB aluOp
  function automatic logic [13:0] expVec(tbSt_e s, bit rdy, bit z);
    case (s)
      TFetch:    return {1'b1, 1'b0, 1'b0, rdy, rdy, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00};
      TDecode:   return {6'b000000, 2'b00, 2'b01, 2'b01, 2'b00};
      TMemAdr:   return {6'b000000, 2'b00, 2'b10, 2'b01, 2'b00};
      TMemRead:  return {6'b101000, 2'b00, 2'b00, 2'b00, 2'b00};
      TMemWb:    return {6'b000001, 2'b01, 2'b00, 2'b00, 2'b00};
      TMemWrite: return {6'b111000, 2'b00, 2'b00, 2'b00, 2'b00};
      TExecR:    return {6'b000000, 2'b00, 2'b10, 2'b00, 2'b10};
      TExecI:    return {6'b000000, 2'b00, 2'b10, 2'b01, 2'b10};
      TAluWb:    return {6'b000001, 2'b00, 2'b00, 2'b00, 2'b00};
      TBeq:      return {1'b0, 1'b0, 1'b0, 1'b0, z, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01};
      TJal:      return {6'b000010, 2'b00, 2'b01, 2'b10, 2'b00};
      default:   return '0;
    endcase
  endfunction

  task automatic checkVal(input string tag, input logic [14:0] got, input logic [14:0] exp);
    nCmp++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic pushCyc(input tbSt_e s, input bit rdy, input string tag);
    expQ.push_back({expVec(s, rdy, zCur), illExp, pulseNext});
    pulseNext = 1'b0;
    rdyQ.push_back(rdy);
    opQ.push_back(opCur);
    zQ.push_back(zCur);
    tagQ.push_back(tag);
  endtask

  task automatic pushMem(input tbSt_e s, input int waits, input string tag);
    for (int i = 0; i < waits; i++) pushCyc(s, 1'b0, {tag, ".wait"});
    pushCyc(s, 1'b1, tag);
  endtask

  task automatic plan(input logic [6:0] o, input bit z, input int fw, input int mw,
                      input string tag);
    opCur = o;
    zCur  = z;
    pushMem(TFetch, fw, {tag, ".F"});
    pushCyc(TDecode, 1'($urandom_range(0, 1)), {tag, ".D"});
    case (o)
      7'b0000011: begin
        pushCyc(TMemAdr, 1'($urandom_range(0, 1)), {tag, ".MA"});
        pushMem(TMemRead, mw, {tag, ".MR"});
        pushCyc(TMemWb, 1'($urandom_range(0, 1)), {tag, ".WB"});
      end
      7'b0100011: begin
        pushCyc(TMemAdr, 1'($urandom_range(0, 1)), {tag, ".MA"});
        pushMem(TMemWrite, mw, {tag, ".MW"});
      end
      7'b0110011: begin
        pushCyc(TExecR, 1'($urandom_range(0, 1)), {tag, ".XR"});
        pushCyc(TAluWb, 1'($urandom_range(0, 1)), {tag, ".WB"});
      end
      7'b0010011: begin
        pushCyc(TExecI, 1'($urandom_range(0, 1)), {tag, ".XI"});
        pushCyc(TAluWb, 1'($urandom_range(0, 1)), {tag, ".WB"});
      end
      7'b1100011: pushCyc(TBeq, 1'($urandom_range(0, 1)), {tag, ".BEQ"});
      7'b1101111: begin
        pushCyc(TJal, 1'($urandom_range(0, 1)), {tag, ".JAL"});
        pushCyc(TAluWb, 1'($urandom_range(0, 1)), {tag, ".WB"});
      end
      default: begin
        illExp    = 1'b1;
        pulseNext = 1'b1;
      end
    endcase
  endtask

  task automatic runCycles(input int n);
    logic [15:0] e;
    string       t;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      memReady = rdyQ.pop_front();
      op       = opQ.pop_front();
      zero     = zQ.pop_front();
      e        = expQ.pop_front();
      t        = tagQ.pop_front();
      #2;
      checkVal(t, obsA, {e[15:2], e[1]});
      checkVal({t, "/pulse"}, obsB, {e[15:2], e[0]});
    end
  endtask

  task automatic runAll();
    runCycles(expQ.size());
  endtask

  task automatic flushPlan();
    expQ.delete();
    rdyQ.delete();
    opQ.delete();
    zQ.delete();
    tagQ.delete();
    illExp    = 1'b0;
    pulseNext = 1'b0;
  endtask

  logic [6:0] opTab [6];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    opTab[0] = 7'b0000011; opTab[1] = 7'b0100011; opTab[2] = 7'b0110011;
    opTab[3] = 7'b0010011; opTab[4] = 7'b1100011; opTab[5] = 7'b1101111;

    // Reset state, with and without memReady asserted.
    #3;
    checkVal("rst", obsA, {expVec(TFetch, 1'b0, 1'b0), 1'b0});
    memReady = 1'b1;
    #1;
    checkVal("rst.rdy", obsA, {expVec(TFetch, 1'b0, 1'b0), 1'b0});
    checkVal("rst.rdy/pulse", obsB, {expVec(TFetch, 1'b0, 1'b0), 1'b0});
    @(negedge clk);
    rst_n    = 1'b1;
    memReady = 1'b0;

    plan(7'b0000011, 1'b0, 0, 0, "lw");    runAll();
    plan(7'b0110011, 1'b0, 0, 0, "rtype"); runAll();
    plan(7'b0010011, 1'b1, 0, 0, "itype"); runAll();
    plan(7'b1100011, 1'b1, 0, 0, "beqT");  runAll();
    plan(7'b1100011, 1'b0, 0, 0, "beqN");  runAll();
    plan(7'b1101111, 1'b0, 0, 0, "jal");   runAll();
    plan(7'b0100011, 1'b0, 0, 2, "swWait"); runAll();
    plan(7'b0000011, 1'b0, 3, 1, "lwWait"); runAll();

    plan(7'b0000000, 1'b0, 0, 0, "ill");   runAll();
    plan(7'b0000011, 1'b0, 0, 0, "lwIll"); runAll();
    plan(7'b1111111, 1'b1, 1, 0, "ill2");  runAll();
    plan(7'b0110011, 1'b0, 0, 0, "rIll");  runAll();

    for (int k = 0; k < 10; k++) begin
      plan(opTab[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), "rnd");
      runAll();
    end

    // Reset while a store waits on memReady: strobes drop at once.
    plan(7'b0100011, 1'b0, 0, 3, "swRst");
    runCycles(5);
    memReady = 1'b1;
    rst_n    = 1'b0;
    #1;
    checkVal("rstMidStore", obsA, {expVec(TFetch, 1'b0, 1'b0), 1'b0});
    checkVal("rstMidStore/pulse", obsB, {expVec(TFetch, 1'b0, 1'b0), 1'b0});
    flushPlan();
    @(negedge clk);
    rst_n    = 1'b1;
    memReady = 1'b0;

    plan(7'b0000011, 1'b0, 0, 0, "lwPost"); runAll();
    plan(7'b1101111, 1'b0, 1, 0, "jalPost"); runAll();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
